// File: rtl/frvp_spi_int_sync_crossing_sink.sv
// Receiving end of the SPI interrupt crossing: synchronizes source-domain interrupt lines,
// deglitches them, latches edge events into a clearable pending register, and drives masked outputs.
module frvp_spi_int_sync_crossing_sink #(
    parameter int unsigned NUM_INT     = 1,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned FILTER_LEN  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_INT-1:0] auto_in_sync,
    input  logic [NUM_INT-1:0] cfg_edge,
    input  logic [NUM_INT-1:0] cfg_mask,
    input  logic               clr_valid,
    input  logic [NUM_INT-1:0] clr_bits,
    output logic [NUM_INT-1:0] pending,
    output logic [NUM_INT-1:0] auto_out,
    output logic               irq_any
);

    logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INT-1:0] synced;
    logic [NUM_INT-1:0] filt;
    logic [NUM_INT-1:0] filt_d_q;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] clr_hit;
    logic [NUM_INT-1:0] pending_d;
    logic [NUM_INT-1:0] pending_q;
    logic [NUM_INT-1:0] auto_out_q;
    logic               irq_any_q;

    // Plain flop chain; no logic between stages so each stage only sees a settled flop output.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= auto_in_sync;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_no_filter
            assign filt = synced;
        end else begin : g_filter
            localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

            logic [CntW-1:0]    cnt_q [NUM_INT];
            logic [NUM_INT-1:0] filt_q;

            // A change is accepted only after FILTER_LEN consecutive mismatching samples.
            always_ff @(posedge clock) begin
                if (reset) begin
                    filt_q <= '0;
                    for (int i = 0; i < int'(NUM_INT); i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < int'(NUM_INT); i++) begin
                        if (synced[i] == filt_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
                            filt_q[i] <= synced[i];
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CntW'(1);
                        end
                    end
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    assign rise    = filt & ~filt_d_q;
    assign clr_hit = clr_bits & {NUM_INT{clr_valid}};

    // Edge lines: rise beats a same-cycle clear. Level lines mirror filt and ignore clears.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < int'(NUM_INT); i++) begin
            if (cfg_edge[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~clr_hit[i]);
            end else begin
                pending_d[i] = filt[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_d_q   <= '0;
            pending_q  <= '0;
            auto_out_q <= '0;
            irq_any_q  <= 1'b0;
        end else begin
            filt_d_q   <= filt;
            pending_q  <= pending_d;
            auto_out_q <= pending_q & ~cfg_mask;
            irq_any_q  <= |(pending_q & ~cfg_mask);
        end
    end

    assign pending  = pending_q;
    assign auto_out = auto_out_q;
    assign irq_any  = irq_any_q;

endmodule

// File: tb/tb_frvp_spi_int_sync_crossing_sink.sv
// Directed bench for the interrupt crossing sink: NUM_INT=4, SYNC_STAGES=2, FILTER_LEN=3,
// giving filt at E0+4, pending at E0+5 and auto_out at E0+6.
module tb_frvp_spi_int_sync_crossing_sink;

    logic       clock;
    logic       reset;
    logic [3:0] auto_in_sync;
    logic [3:0] cfg_edge;
    logic [3:0] cfg_mask;
    logic       clr_valid;
    logic [3:0] clr_bits;
    logic [3:0] pending;
    logic [3:0] auto_out;
    logic       irq_any;

    int pass_cnt;
    int total_cnt;

    frvp_spi_int_sync_crossing_sink #(
        .NUM_INT    (4),
        .SYNC_STAGES(2),
        .FILTER_LEN (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .auto_in_sync(auto_in_sync),
        .cfg_edge    (cfg_edge),
        .cfg_mask    (cfg_mask),
        .clr_valid   (clr_valid),
        .clr_bits    (clr_bits),
        .pending     (pending),
        .auto_out    (auto_out),
        .irq_any     (irq_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns 1 time unit after a rising edge: outputs are settled, new inputs meet the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        auto_in_sync = 4'h0;
        clr_valid    = 1'b0;
        clr_bits     = 4'h0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        auto_in_sync = 4'hF;
        cfg_edge     = 4'hF;
        cfg_mask     = 4'h0;
        clr_valid    = 1'b0;
        clr_bits     = 4'h0;
        reset        = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (pending !== 4'h0) $display("FAIL reset_pending cyc%0d: got %h want 0", c, pending);
            else pass_cnt++;
            total_cnt++;
            if (auto_out !== 4'h0) $display("FAIL reset_auto_out cyc%0d: got %h want 0", c, auto_out);
            else pass_cnt++;
            total_cnt++;
            if (irq_any !== 1'b0) $display("FAIL reset_irq_any cyc%0d: got %b want 0", c, irq_any);
            else pass_cnt++;
        end
        reset = 1'b0;
        repeat (5) tick();
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL reset_early_pending: got %h want 0", pending);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 4'hF) $display("FAIL reset_release_pending: got %h want f", pending);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        cfg_edge = 4'hF;
        cfg_mask = 4'h0;
        do_reset();
        auto_in_sync = 4'h2;
        repeat (5) tick();
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL lat_pending_e4: got %h want 0", pending);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 4'h2) $display("FAIL lat_pending_e5: got %h want 2", pending);
        else pass_cnt++;
        total_cnt++;
        if (auto_out !== 4'h0) $display("FAIL lat_auto_out_e5: got %h want 0", auto_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (auto_out !== 4'h2) $display("FAIL lat_auto_out_e6: got %h want 2", auto_out);
        else pass_cnt++;
        total_cnt++;
        if (irq_any !== 1'b1) $display("FAIL lat_irq_any_e6: got %b want 1", irq_any);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        cfg_edge = 4'hF;
        cfg_mask = 4'h0;
        do_reset();
        auto_in_sync = 4'h1;
        repeat (2) tick();
        auto_in_sync = 4'h0;
        repeat (10) tick();
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL glitch_short_pulse: got %h want 0", pending);
        else pass_cnt++;
        auto_in_sync = 4'h1;
        repeat (4) tick();
        auto_in_sync = 4'h0;
        repeat (10) tick();
        total_cnt++;
        if (pending !== 4'h1) $display("FAIL glitch_long_pulse: got %h want 1", pending);
        else pass_cnt++;
    endtask

    task automatic test_set_over_clear();
        cfg_edge = 4'hF;
        cfg_mask = 4'h0;
        do_reset();
        auto_in_sync = 4'h1;
        repeat (5) tick();
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL soc_before_rise: got %h want 0", pending);
        else pass_cnt++;
        // rise[0] is high in this cycle; the clear lands on the same edge.
        clr_valid = 1'b1;
        clr_bits  = 4'h1;
        tick();
        clr_valid = 1'b0;
        clr_bits  = 4'h0;
        total_cnt++;
        if (pending !== 4'h1) $display("FAIL soc_set_wins: got %h want 1", pending);
        else pass_cnt++;
        repeat (3) tick();
        clr_valid = 1'b1;
        clr_bits  = 4'h1;
        tick();
        clr_valid = 1'b0;
        clr_bits  = 4'h0;
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL soc_clear: got %h want 0", pending);
        else pass_cnt++;
        total_cnt++;
        if (auto_out !== 4'h1) $display("FAIL soc_auto_out_lag: got %h want 1", auto_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (auto_out !== 4'h0) $display("FAIL soc_auto_out_fall: got %h want 0", auto_out);
        else pass_cnt++;
    endtask

    task automatic test_level_mask();
        cfg_edge = 4'h0;
        cfg_mask = 4'h4;
        do_reset();
        auto_in_sync = 4'h4;
        repeat (8) tick();
        total_cnt++;
        if (pending !== 4'h4) $display("FAIL lvl_pending: got %h want 4", pending);
        else pass_cnt++;
        total_cnt++;
        if (auto_out !== 4'h0) $display("FAIL lvl_masked_out: got %h want 0", auto_out);
        else pass_cnt++;
        total_cnt++;
        if (irq_any !== 1'b0) $display("FAIL lvl_masked_irq: got %b want 0", irq_any);
        else pass_cnt++;
        cfg_mask = 4'h0;
        tick();
        total_cnt++;
        if (auto_out !== 4'h4) $display("FAIL lvl_unmask_out: got %h want 4", auto_out);
        else pass_cnt++;
        total_cnt++;
        if (irq_any !== 1'b1) $display("FAIL lvl_unmask_irq: got %b want 1", irq_any);
        else pass_cnt++;
        clr_valid = 1'b1;
        clr_bits  = 4'hF;
        tick();
        clr_valid = 1'b0;
        clr_bits  = 4'h0;
        total_cnt++;
        if (pending !== 4'h4) $display("FAIL lvl_clear_ignored: got %h want 4", pending);
        else pass_cnt++;
        auto_in_sync = 4'h0;
        repeat (5) tick();
        total_cnt++;
        if (pending !== 4'h4) $display("FAIL lvl_drop_e4: got %h want 4", pending);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL lvl_drop_e5: got %h want 0", pending);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        cfg_edge = 4'hF;
        cfg_mask = 4'h0;
        do_reset();
        auto_in_sync = 4'hA;
        repeat (8) tick();
        total_cnt++;
        if (pending !== 4'hA) $display("FAIL mid_pending_before: got %h want a", pending);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL mid_pending_reset: got %h want 0", pending);
        else pass_cnt++;
        total_cnt++;
        if (auto_out !== 4'h0) $display("FAIL mid_auto_out_reset: got %h want 0", auto_out);
        else pass_cnt++;
        total_cnt++;
        if (irq_any !== 1'b0) $display("FAIL mid_irq_reset: got %b want 0", irq_any);
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if (pending !== 4'h0) $display("FAIL mid_repend_early: got %h want 0", pending);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 4'hA) $display("FAIL mid_repend: got %h want a", pending);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (auto_out !== 4'hA) $display("FAIL mid_auto_out_repend: got %h want a", auto_out);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        reset        = 1'b1;
        auto_in_sync = 4'h0;
        cfg_edge     = 4'h0;
        cfg_mask     = 4'h0;
        clr_valid    = 1'b0;
        clr_bits     = 4'h0;
        test_reset();
        test_latency();
        test_glitch();
        test_set_over_clear();
        test_level_mask();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/frvp_spi_int_sync_crossing_sink.md
# frvp_spi_int_sync_crossing_sink

Receiving end of the SPI block's interrupt crossing. It takes the registered, glitch-free interrupt lines driven from the source clock domain and synchronizes them into the local `clock` domain. It then deglitches each line, latches edge-mode events in a pending register with software clear, and drives masked interrupt outputs toward the interrupt controller.

## Interface
Parameters:
- `NUM_INT`, 1, number of interrupt lines (1..32).
- `SYNC_STAGES`, 3, synchronizer flop depth (legal range 2..4).
- `FILTER_LEN`, 2, consecutive stable cycles required before a synchronized change is accepted. 0 bypasses the filter.

Ports (clock and reset first):
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `auto_in_sync`  in  NUM_INT  interrupt lines from the source domain; asynchronous to `clock`.
- `cfg_edge`  in  NUM_INT  per line: 1 = edge mode (latched), 0 = level mode.
- `cfg_mask`  in  NUM_INT  per line: 1 = masked (suppressed at output).
- `clr_valid`  in  1  single-cycle strobe that clears pending bits.
- `clr_bits`  in  NUM_INT  pending bits to clear when `clr_valid` = 1.
- `pending`  out  NUM_INT  pending status, unmasked.
- `auto_out`  out  NUM_INT  registered interrupt outputs, `pending & ~cfg_mask`.
- `irq_any`  out  1  registered OR-reduction of `auto_out`.

## Operation
- **Synchronizer.**
  - Each line passes through `SYNC_STAGES` flops.
  - All stages reset to 0.
  - No logic sits between stages.
- **Deglitch filter (per line).**
  - Holds a filtered value `filt` and a counter of width clog2(FILTER_LEN+1).
  - Synced value equals `filt`: counter is cleared to 0.
  - Synced value differs from `filt`: counter increments.
  - When the counter reaches FILTER_LEN-1 and the mismatch is still present, `filt` takes the synced value and the counter clears.
  - A mismatch that disappears before that point is discarded and the counter clears.
  - With FILTER_LEN = 0, `filt` is the synced value (wire) and no counter is generated.
  - `filt` and the counter reset to 0.
- **Edge detect.** `rise = filt & ~filt_d`, where `filt_d` is `filt` delayed one cycle, reset to 0.
- **Pending, edge mode.**
  - Set by `rise`.
  - Cleared when `clr_valid` = 1 and the corresponding `clr_bits` bit = 1.
  - `rise` and clear in the same cycle: set wins and the bit stays 1.
  - A rise while already pending is absorbed; no counting.
- **Pending, level mode.**
  - The pending bit is a register following `filt` each cycle.
  - Clear strobes are ignored.
- **Mode change.** Changing `cfg_edge` takes effect on the next cycle. A line switched from edge to level drops its latched value and follows `filt`.
- **Masking.**
  - `cfg_mask` affects only `auto_out`/`irq_any`.
  - Masked lines still set `pending`.
  - Unmasking a pending line raises `auto_out` one cycle later.
- **Reset.**
  - `pending`, `auto_out` and `irq_any` all reset to 0.
  - Reset asserted mid-operation discards all synchronizer, filter and pending state in the same cycle.
  - After reset deassertion, a line already high is treated as a fresh rising edge.

## Timing
- Edge E0 is the first `clock` edge at which a new `auto_in_sync` value meets setup.
- Synced value updates at E0+SYNC_STAGES-1.
- `filt` updates at E0+SYNC_STAGES+FILTER_LEN-1.
- `pending` updates at E0+SYNC_STAGES+FILTER_LEN.
- `auto_out` and `irq_any` update at E0+SYNC_STAGES+FILTER_LEN+1.
- Total latency is SYNC_STAGES+FILTER_LEN+2 edges when counted from the edge before E0 (i.e. including the sampling edge).
- Minimum accepted source pulse width is FILTER_LEN+1 `clock` cycles; shorter pulses may be dropped.
- `clr_valid` is sampled every cycle; the cleared bit reads 0 on `pending` the next cycle.
- `auto_out` falls the cycle after that.

## Test plan
- **Reset values.** Assert `reset` for 3 cycles with `auto_in_sync`=4'hF. Required: `pending`, `auto_out` and `irq_any` are 0 throughout reset. After release, `pending`=4'hF in edge mode.
- **Latency.** NUM_INT=4, SYNC_STAGES=2, FILTER_LEN=3, `cfg_edge`=4'hF, mask 0. Raise `auto_in_sync[1]` just before edge E0. Required: `pending`=4'h2 after edge E0+5 and `auto_out`=4'h2 after edge E0+6.
- **Glitch rejection.** Same configuration; pulse `auto_in_sync[0]` high for 2 cycles. Required: `pending[0]` stays 0. A 4-cycle pulse sets `pending[0]` to 1.
- **Set-over-clear.** Edge mode; align `clr_valid`=1, `clr_bits`=4'h1 with the cycle `rise[0]`=1. Required: `pending[0]` stays 1. A later clear with no rise gives `pending[0]`=0 the next cycle.
- **Level mode and mask.** `cfg_edge`=0, `cfg_mask`=4'h4. Hold `auto_in_sync[2]`=1. Required: `pending`=4'h4 and `auto_out`=0. Clearing the mask gives `auto_out`=4'h4 one cycle later. A clear strobe has no effect. Dropping the input returns `pending` to 0 after SYNC_STAGES+FILTER_LEN cycles.
- **Mid-operation reset.** Pulse `reset` for 1 cycle while `pending`=4'hA. Required: all outputs are 0 the next cycle, and the still-high inputs re-pend after the full latency.
